// File: rtl/udp_port_dispatch.sv
// udp_port_dispatch: routes UDP payloads to NUM_CH streams by dest port.
// Ports: cfg_*, s_udp_hdr_*, s_axis_*, m_axis_*, busy, drop_count,
//   error_length; UDP_DISPATCH_STATS_EN adds stats_clr, ch_frame_count.
module udp_port_dispatch #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  logic_clk,
  input  logic                  logic_rst_n,
  input  logic [16*NUM_CH-1:0]  cfg_port,
  input  logic [NUM_CH-1:0]     cfg_en,
  input  logic                  s_udp_hdr_valid,
  output logic                  s_udp_hdr_ready,
  input  logic [15:0]           s_udp_dest_port,
  input  logic [15:0]           s_udp_length,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic [NUM_CH-1:0]     m_axis_tvalid,
  input  logic [NUM_CH-1:0]     m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  error_length
`ifdef UDP_DISPATCH_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [CNT_W*NUM_CH-1:0] ch_frame_count
`endif
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, hit_idx;
  logic             hit;
  logic [15:0]      exp_len_q, byte_cnt_q;
  logic [CNT_W-1:0] drop_q;
  logic             err_q;
  logic             hdr_hs, beat, len_bad, to_drop;
  logic             fwd_last;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_en[i] && cfg_port[16*i +: 16] == s_udp_dest_port) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign hdr_hs   = s_udp_hdr_valid && s_udp_hdr_ready;
  assign beat     = s_axis_tvalid && s_axis_tready;
  assign len_bad  = (byte_cnt_q + 16'd1) != exp_len_q;
  assign to_drop  = !hit || (s_udp_length < 16'd8);
  assign fwd_last = (state_q == FWD) && beat && s_axis_tlast;

  always_comb begin
    state_d         = state_q;
    s_udp_hdr_ready = 1'b0;
    s_axis_tready   = 1'b0;
    m_axis_tvalid   = '0;
    m_axis_tuser    = s_axis_tuser;
    unique case (state_q)
      IDLE: begin
        s_udp_hdr_ready = 1'b1;
        if (s_udp_hdr_valid)
          state_d = to_drop ? DROP : FWD;
      end
      FWD: begin
        m_axis_tvalid[sel_q] = s_axis_tvalid;
        s_axis_tready        = m_axis_tready[sel_q];
        if (s_axis_tlast && len_bad)
          m_axis_tuser = 1'b1;
        if (beat && s_axis_tlast)
          state_d = IDLE;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (beat && s_axis_tlast)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = s_axis_tlast;
  assign busy         = (state_q != IDLE);
  assign drop_count   = drop_q;
  assign error_length = err_q;

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      exp_len_q  <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (hdr_hs) begin
        sel_q      <= hit_idx;
        exp_len_q  <= s_udp_length - 16'd8;
        byte_cnt_q <= '0;
      end
      if (state_q == FWD && beat) begin
        byte_cnt_q <= byte_cnt_q + 16'd1;
        if (s_axis_tlast)
          err_q <= len_bad;
      end
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      drop_q <= '0;
    end else begin
`ifdef UDP_DISPATCH_STATS_EN
      if (stats_clr)
        drop_q <= '0;
      else if (hdr_hs && to_drop && drop_q != '1)
        drop_q <= drop_q + 1'b1;
`else
      if (hdr_hs && to_drop && drop_q != '1)
        drop_q <= drop_q + 1'b1;
`endif
    end
  end

`ifdef UDP_DISPATCH_STATS_EN
  logic [CNT_W-1:0] frm_q [NUM_CH];

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      for (int c = 0; c < NUM_CH; c++)
        frm_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (stats_clr)
          frm_q[c] <= '0;
        else if (fwd_last && sel_q == SEL_W'(c) && frm_q[c] != '1)
          frm_q[c] <= frm_q[c] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_frame_count[CNT_W*g +: CNT_W] = frm_q[g];
  end
`else
  logic unused_fwd_last;
  assign unused_fwd_last = fwd_last;
`endif

endmodule

// File: tb/tb_udp_port_dispatch.sv
// tb_udp_port_dispatch: scoreboard bench for udp_port_dispatch.
// Drives headers/payload, checks routing, drops, length errors, reset.
module tb_udp_port_dispatch;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [16*NUM_CH-1:0] cfg_port;
  logic [NUM_CH-1:0]    cfg_en;
  logic                 s_udp_hdr_valid;
  logic                 s_udp_hdr_ready;
  logic [15:0]          s_udp_dest_port;
  logic [15:0]          s_udp_length;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic                 s_axis_tuser;
  logic [7:0]           m_axis_tdata;
  logic [NUM_CH-1:0]    m_axis_tvalid;
  logic [NUM_CH-1:0]    m_axis_tready;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;
  logic                 busy;
  logic [CNT_W-1:0]     drop_count;
  logic                 error_length;
`ifdef UDP_DISPATCH_STATS_EN
  logic                      stats_clr;
  logic [CNT_W*NUM_CH-1:0]   ch_frame_count;
`endif

  always #5 clk = ~clk;

  udp_port_dispatch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .logic_clk      (clk),
    .logic_rst_n    (rst_n),
    .cfg_port       (cfg_port),
    .cfg_en         (cfg_en),
    .s_udp_hdr_valid(s_udp_hdr_valid),
    .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_dest_port(s_udp_dest_port),
    .s_udp_length   (s_udp_length),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .busy           (busy),
    .drop_count     (drop_count),
    .error_length   (error_length)
`ifdef UDP_DISPATCH_STATS_EN
    ,
    .stats_clr      (stats_clr),
    .ch_frame_count (ch_frame_count)
`endif
  );

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
    logic       l;
    logic       u;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   base   = 0;
  int   last_cyc = 0;
  int   hs_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      check("onehot", 32'($onehot0(m_axis_tvalid)), 1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_axis_tvalid[c] && m_axis_tready[c]) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = q.pop_front();
            check("out_ch", c, 32'(e.ch));
            check("out_data", 32'(m_axis_tdata), 32'(e.d));
            check("out_last", 32'(m_axis_tlast), 32'(e.l));
            check("out_user", 32'(m_axis_tuser), 32'(e.u));
          end
        end
      end
    end
  end

  task automatic push_exp(int ch, int b, int n, bit bad, bit nolast);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ch = 3'(ch);
      e.d  = 8'(b + i);
      e.l  = !nolast && (i == n - 1);
      e.u  = !nolast && (i == n - 1) && bad;
      q.push_back(e);
    end
  endtask

  task automatic send_hdr(logic [15:0] port, logic [15:0] len);
    int g = 0;
    s_udp_hdr_valid = 1'b1;
    s_udp_dest_port = port;
    s_udp_length    = len;
    while (g < 100) begin
      @(negedge clk);
      if (s_udp_hdr_ready) break;
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) check("hdr_timeout", 1, 0);
    else hs_cyc = cyc + 1;
    @(posedge clk); #1;
    s_udp_hdr_valid = 1'b0;
  endtask

  // mode 0: plain, 1: toggle m_axis_tready[0], 2: expect drain
  task automatic send_payload(int n, int b, int mode, bit nolast,
                              bit pre, logic [15:0] hp,
                              logic [15:0] hl);
    int i = 0;
    int g = 0;
    bit tv;
    while (i < n && g < 500) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(b + i);
      s_axis_tlast  = !nolast && (i == n - 1);
      if (pre && i == n - 1) begin
        s_udp_hdr_valid = 1'b1;
        s_udp_dest_port = hp;
        s_udp_length    = hl;
      end
      tv = (g % 2 == 0);
      if (mode == 1) m_axis_tready[0] = tv;
      @(negedge clk);
      if (mode == 1)
        check("tready_mirror", 32'(s_axis_tready), 32'(tv));
      if (mode == 2) begin
        check("drop_tready", 32'(s_axis_tready), 1);
        check("drop_no_valid", 32'(m_axis_tvalid), 0);
      end
      if (s_axis_tready) begin
        if (s_axis_tlast) last_cyc = cyc + 1;
        i++;
      end
      @(posedge clk); #1;
      g++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = '1;
    if (i < n) check("payload_timeout", i, n);
  endtask

  task automatic run_frame(logic [15:0] port, logic [15:0] len,
                           int n, int ch, bit bad, int mode);
    if (ch >= 0) push_exp(ch, base, n, bad, 1'b0);
    send_hdr(port, len);
    send_payload(n, base, mode, 1'b0, 1'b0, 16'h0, 16'h0);
    base += n;
  endtask

  task automatic end_checks(bit e);
    @(negedge clk);
    check("busy_end", 32'(busy), 0);
    check("err_len", 32'(error_length), 32'(e));
    @(posedge clk); #1;
    @(negedge clk);
    check("err_pulse", 32'(error_length), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_port        = {16'h1235, 16'h1234};
    cfg_en          = 2'b11;
    s_udp_hdr_valid = 1'b0;
    s_udp_dest_port = '0;
    s_udp_length    = '0;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    s_axis_tuser    = 1'b0;
    m_axis_tready   = '1;
`ifdef UDP_DISPATCH_STATS_EN
    stats_clr       = 1'b0;
`endif
    #1;
    check("rst_hdr_ready", 32'(s_udp_hdr_ready), 1);
    check("rst_tready", 32'(s_axis_tready), 0);
    check("rst_mvalid", 32'(m_axis_tvalid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_err", 32'(error_length), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("idle_stall", 32'(s_axis_tready), 0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;

    run_frame(16'h1235, 16'd12, 4, 1, 1'b0, 0);
    end_checks(1'b0);
    check("drop0", 32'(drop_count), 0);

    run_frame(16'h9999, 16'd20, 12, -1, 1'b0, 2);
    end_checks(1'b0);
    check("drop1", 32'(drop_count), 1);

    run_frame(16'h1234, 16'd14, 6, 0, 1'b0, 1);
    end_checks(1'b0);

    run_frame(16'h1234, 16'd10, 3, 0, 1'b1, 0);
    end_checks(1'b1);

    run_frame(16'h1234, 16'd6, 2, -1, 1'b0, 2);
    end_checks(1'b0);
    check("drop_short", 32'(drop_count), 2);

    cfg_en = 2'b01;
    run_frame(16'h1235, 16'd9, 1, -1, 1'b0, 2);
    end_checks(1'b0);
    check("drop_dis", 32'(drop_count), 3);

    cfg_en   = 2'b11;
    cfg_port = {16'h4321, 16'h4321};
    run_frame(16'h4321, 16'd10, 2, 0, 1'b0, 0);
    end_checks(1'b0);
    cfg_port = {16'h1235, 16'h1234};

    push_exp(1, base, 3, 1'b0, 1'b0);
    push_exp(0, base + 3, 2, 1'b0, 1'b0);
    send_hdr(16'h1235, 16'd11);
    send_payload(3, base, 0, 1'b0, 1'b1, 16'h1234, 16'd10);
    send_hdr(16'h1234, 16'd10);
    check("b2b_gap", hs_cyc - last_cyc, 1);
    send_payload(2, base + 3, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    base += 5;
    end_checks(1'b0);

    push_exp(1, base, 2, 1'b0, 1'b1);
    send_hdr(16'h1235, 16'd20);
    send_payload(2, base, 0, 1'b1, 1'b0, 16'h0, 16'h0);
    base += 2;
    s_axis_tvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_hdr_ready", 32'(s_udp_hdr_ready), 1);
    check("arst_tready", 32'(s_axis_tready), 0);
    check("arst_mvalid", 32'(m_axis_tvalid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_drop", 32'(drop_count), 0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(16'h1234, 16'd9, 1, 0, 1'b0, 0);
    end_checks(1'b0);

`ifdef UDP_DISPATCH_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_frame(16'h1234, 16'd9, 1, 0, 1'b0, 0);
      end_checks(1'b0);
    end
    run_frame(16'h1235, 16'd10, 2, 1, 1'b0, 0);
    end_checks(1'b0);
    run_frame(16'h7777, 16'd9, 1, -1, 1'b0, 2);
    end_checks(1'b0);
    check("stat_ch0", 32'(ch_frame_count[15:0]), 3);
    check("stat_ch1", 32'(ch_frame_count[31:16]), 1);
    check("stat_drop", 32'(drop_count), 1);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    check("clr_frames", 32'(ch_frame_count), 0);
    check("clr_drop", 32'(drop_count), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
